conv_maxpool: RTL and testbench
===============================

Name: conv_maxpool

Overview:
- Downstream stage of the convolution engine: consumes its raster-order stream of signed 16-bit activations (one frame = N×N samples) and performs 2×2, stride-2 max pooling.
- Emits floor(N/2)² pooled samples per frame, in raster order.
- Frame size comes from a one-cycle config pulse issued by the controller alongside the convolution config.

Parameters:
- DATA_W, 16, sample width (signed, two's complement).
- MAX_SIZE, 8, largest supported frame side N; sizes the line buffer to MAX_SIZE/2 entries.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_valid  in  1  one-cycle pulse; cfg_size is sampled on this cycle.
- cfg_size  in  4  frame side N.
- in_valid  in  1  input sample qualifier; gaps allowed.
- in_data  in  DATA_W  signed input sample.
- out_valid  out  1  pooled sample valid.
- out_data  out  DATA_W  signed pooled sample.
- frame_done  out  1  one-cycle pulse after the last input sample of a frame.
- busy  out  1  high while in RUN.

Behaviour:
- One clock domain (clk). Reset is asynchronous, active-low (rst_n). All state is registered.
- Reset values: out_valid=0, out_data=0, frame_done=0, busy=0, state=IDLE, all counters 0, line buffer and hold register 0.
- State machine:
  - IDLE: waits for cfg_valid. in_valid is ignored.
    - cfg_size<2: config ignored, stay in IDLE.
    - cfg_size>MAX_SIZE: latch MAX_SIZE.
    - Otherwise latch cfg_size as N.
    - On a valid config, go to RUN and clear row counter r and column counter c.
  - RUN: busy=1. Each in_valid cycle accepts one sample at position (r,c).
    - c wraps from N-1 to 0 and increments r.
    - cfg_valid in RUN is ignored.
    - On acceptance of sample (N-1,N-1), go to IDLE; frame_done pulses on the next cycle.
- Pooling datapath (only for r<2·floor(N/2) and c<2·floor(N/2); other samples are accepted and discarded):
  - c even: hold <= in_data.
  - c odd: pm = signed max(hold, in_data).
    - r even: linebuf[c>>1] <= pm.
    - r odd: out_data <= signed max(linebuf[c>>1], pm) and out_valid <= 1 on the next edge.
- Latency: out_valid rises exactly 1 cycle after the bottom-right sample of each 2×2 window is accepted. out_valid is high for 1 cycle per output.
- When N is odd, the trailing row and column are dropped.
- out_valid/out_data are not back-pressured. out_data holds its last value when out_valid=0.
- Comparisons are signed; ties are irrelevant (equal values).
- For even N, the last out_valid and frame_done occur in the same cycle.
- Reset mid-frame: returns to IDLE immediately. Partial results are discarded and no frame_done is issued.

Optional Feature:
- Macro AVG_POOL_EN.
- Defined:
  - Adds input port avg_mode (1 bit), latched on cfg_valid.
  - When the latched value is 1, output = (sum of 4 window samples) >>> 2, using an arithmetic shift (floor toward −∞).
  - The sum is carried at DATA_W+2 bits: linebuf stores the pair sum (DATA_W+1 bits) instead of the pair max.
  - avg_mode=0 behaves exactly as max pooling.
- Undefined:
  - avg_mode port is absent.
  - Max pooling only; linebuf is DATA_W wide.

Test Plan:
- cfg N=4, in_valid continuous, stream 0..15 -> out_valid ×4 with out_data 5,7,13,15. The out_valid for 5 occurs 1 cycle after sample 5 is accepted. frame_done coincides with out 15.
- cfg N=2, stream −5,−3,−8,−1 -> single output −1. Checks signed compare.
- cfg N=5, stream 0..24 -> outputs 6,8,16,18. No output for row 4 or column 4. frame_done 1 cycle after sample 24. busy falls after sample 24.
- cfg N=4, ramp 0..15 with in_valid toggled 1/0 plus random 3-cycle gaps -> same values 5,7,13,15, each 1 cycle after its window completes. cfg_valid pulsed mid-frame is ignored.
- cfg_size=12 -> clamped to 8: 64 samples required, 16 outputs. cfg_size=1 -> stays IDLE, busy=0, no output.
- rst_n low after 6 samples of an N=4 frame -> all outputs 0, IDLE. A new N=4 frame 0..15 then yields 5,7,13,15. With AVG_POOL_EN, avg_mode=1, same frame yields 2,4,10,12.

Source files
------------

// File: rtl/conv_maxpool_if.sv
`default_nettype none
// ============================================================================
//  Module      : conv_maxpool_if
//  Description : Config, sample-stream and result bundle for conv_maxpool.
//                The avg_mode signal exists only when AVG_POOL_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface conv_maxpool_if #(
    parameter int DATA_W = 16
);
    logic              cfg_valid;
    logic [3:0]        cfg_size;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              frame_done;
    logic              busy;
`ifdef AVG_POOL_EN
    logic              avg_mode;
`endif

    // Controller / upstream side
    modport master (
        output cfg_valid,
        output cfg_size,
        output in_valid,
        output in_data,
`ifdef AVG_POOL_EN
        output avg_mode,
`endif
        input  out_valid,
        input  out_data,
        input  frame_done,
        input  busy
    );

    // Pooling stage side
    modport slave (
        input  cfg_valid,
        input  cfg_size,
        input  in_valid,
        input  in_data,
`ifdef AVG_POOL_EN
        input  avg_mode,
`endif
        output out_valid,
        output out_data,
        output frame_done,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/conv_maxpool.sv
`default_nettype none
// ============================================================================
//  Module      : conv_maxpool
//  Description : 2x2 stride-2 pooling of a raster-order N x N signed sample
//                stream. One pooled sample per window, emitted one cycle
//                after the window's bottom-right sample is accepted.
//                Optional macro AVG_POOL_EN adds average pooling selected by
//                avg_mode (latched with the config pulse).
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_maxpool #(
    parameter int DATA_W   = 16,
    parameter int MAX_SIZE = 8
) (
    input wire            clk,
    input wire            rst_n,
    conv_maxpool_if.slave bus
);

    localparam int         c_LB_DEPTH = MAX_SIZE / 2;
    localparam int         c_LB_AW    = (c_LB_DEPTH > 1) ? $clog2(c_LB_DEPTH) : 1;
    localparam logic [3:0] c_MAX_N    = 4'(MAX_SIZE);
`ifdef AVG_POOL_EN
    // Row-pair sums need one extra bit of headroom
    localparam int         c_LB_W     = DATA_W + 1;
`else
    localparam int         c_LB_W     = DATA_W;
`endif

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_RUN   = 1'b1;

    logic [0:0] r_state;
    logic [0:0] w_state_nxt;
    logic       w_busy;

    logic [3:0] r_n;
    logic [3:0] r_row;
    logic [3:0] r_col;
    logic [3:0] w_n_cfg;
    logic [3:0] w_pool_lim;
    logic       w_cfg_ok;
    logic       w_accept;
    logic       w_last_col;
    logic       w_last;
    logic       w_in_pool;

    logic signed [DATA_W-1:0] w_in;
    logic signed [DATA_W-1:0] r_hold;
    logic signed [DATA_W-1:0] w_pm;
    logic signed [DATA_W-1:0] w_lb_max;
    logic signed [DATA_W-1:0] w_max_out;
    logic signed [DATA_W-1:0] w_out;
    logic        [c_LB_W-1:0] r_lb [c_LB_DEPTH];
    logic        [c_LB_W-1:0] w_lb_rd;
    logic        [c_LB_W-1:0] w_lb_wr;
    logic       [c_LB_AW-1:0] w_lb_idx;

    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic              r_frame_done;

    // ---------------------------------------------------------------- control
    assign w_n_cfg    = (bus.cfg_size > c_MAX_N) ? c_MAX_N : bus.cfg_size;
    assign w_cfg_ok   = (r_state == c_ST_IDLE) && bus.cfg_valid && (bus.cfg_size >= 4'd2);
    assign w_accept   = (r_state == c_ST_RUN) && bus.in_valid;
    assign w_last_col = (r_col == r_n - 4'd1);
    assign w_last     = w_last_col && (r_row == r_n - 4'd1);
    // Odd N drops the trailing row/column: only the even-sized core is pooled
    assign w_pool_lim = {r_n[3:1], 1'b0};
    assign w_in_pool  = (r_row < w_pool_lim) && (r_col < w_pool_lim);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: start on an accepted config, finish on the last sample
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (w_cfg_ok)            w_state_nxt = c_ST_RUN;
            c_ST_RUN:  if (w_accept && w_last)  w_state_nxt = c_ST_IDLE;
            default:                            w_state_nxt = c_ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        w_busy = 1'b0;
        if (r_state == c_ST_RUN) begin
            w_busy = 1'b1;
        end
    end

    // Frame size latch and raster position counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_n   <= 4'd0;
            r_row <= 4'd0;
            r_col <= 4'd0;
        end else if (w_cfg_ok) begin
            r_n   <= w_n_cfg;
            r_row <= 4'd0;
            r_col <= 4'd0;
        end else if (w_accept) begin
            if (w_last_col) begin
                r_col <= 4'd0;
                r_row <= r_row + 4'd1;
            end else begin
                r_col <= r_col + 4'd1;
            end
        end
    end

    // --------------------------------------------------------------- datapath
    assign w_in      = $signed(bus.in_data);
    assign w_lb_idx  = r_col[c_LB_AW:1];
    assign w_lb_rd   = r_lb[w_lb_idx];
    assign w_pm      = (w_in > r_hold) ? w_in : r_hold;
    assign w_lb_max  = w_lb_rd[DATA_W-1:0];
    assign w_max_out = (w_lb_max > w_pm) ? w_lb_max : w_pm;

`ifdef AVG_POOL_EN
    logic                     r_avg;
    logic signed [DATA_W:0]   w_pair_sum;
    logic signed [DATA_W+1:0] w_quad_sum;

    // Averaging mode is fixed for the whole frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_avg <= 1'b0;
        end else if (w_cfg_ok) begin
            r_avg <= bus.avg_mode;
        end
    end

    assign w_pair_sum = {r_hold[DATA_W-1], r_hold} + {w_in[DATA_W-1], w_in};
    assign w_quad_sum = {w_lb_rd[c_LB_W-1], w_lb_rd} + {w_pair_sum[DATA_W], w_pair_sum};
    // Taking bits [DATA_W+1:2] is the arithmetic >>>2 (floor) truncated to DATA_W
    assign w_out      = r_avg ? w_quad_sum[DATA_W+1:2] : w_max_out;
    assign w_lb_wr    = r_avg ? w_pair_sum : {w_pm[DATA_W-1], w_pm};
`else
    assign w_out      = w_max_out;
    assign w_lb_wr    = w_pm;
`endif

    // Pair reduction per row, window reduction on odd rows; result registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold       <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_frame_done <= 1'b0;
            for (int i = 0; i < c_LB_DEPTH; i++) begin
                r_lb[i] <= '0;
            end
        end else begin
            r_out_valid  <= 1'b0;
            r_frame_done <= w_accept && w_last;
            if (w_accept && w_in_pool) begin
                if (!r_col[0]) begin
                    r_hold <= w_in;
                end else if (!r_row[0]) begin
                    r_lb[w_lb_idx] <= w_lb_wr;
                end else begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= w_out;
                end
            end
        end
    end

    assign bus.out_valid  = r_out_valid;
    assign bus.out_data   = r_out_data;
    assign bus.frame_done = r_frame_done;
    assign bus.busy       = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_conv_maxpool.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv_maxpool
//  Description : Directed self-checking bench for conv_maxpool.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_maxpool;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    int   samples[$];
    int   exp_pos[$];
    int   exp_val[$];

    conv_maxpool_if #(.DATA_W(16)) bus ();

    conv_maxpool #(
        .DATA_W   (16),
        .MAX_SIZE (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int size, input bit avg, input bit exp_busy);
        bus.cfg_valid = 1'b1;
        bus.cfg_size  = 4'(size);
`ifdef AVG_POOL_EN
        bus.avg_mode  = avg;
`else
        if (avg) $display("note: avg_mode requested without AVG_POOL_EN");
`endif
        tick();
        bus.cfg_valid = 1'b0;
        chk("cfg_busy", {31'd0, bus.busy}, {31'd0, exp_busy});
    endtask

    task automatic load_ramp(input int count);
        samples.delete();
        for (int i = 0; i < count; i++) samples.push_back(i);
    endtask

    // Streams the sample queue; checks outputs after every cycle
    task automatic run_frame(input string tag, input bit gaps);
        int  k;
        int  nidle;
        int  last_out;
        bit  exp_v;
        k = 0;
        last_out = 0;
        for (int i = 0; i < samples.size(); i++) begin
            if (gaps) begin
                nidle = (i % 2 == 0) ? 1 : 0;
                if ($urandom_range(0, 3) == 0) nidle += 3;
                for (int g = 0; g < nidle; g++) begin
                    bus.in_valid = 1'b0;
                    bus.in_data  = 16'h7fff;
                    tick();
                    chk({tag, "_gap_valid"}, {31'd0, bus.out_valid}, 32'd0);
                    chk({tag, "_gap_done"}, {31'd0, bus.frame_done}, 32'd0);
                end
            end
            bus.in_valid = 1'b1;
            bus.in_data  = 16'(samples[i]);
            if (gaps && i == 8) begin
                bus.cfg_valid = 1'b1;
                bus.cfg_size  = 4'd2;
            end
            tick();
            bus.cfg_valid = 1'b0;
            exp_v = (k < exp_pos.size()) && (exp_pos[k] == i);
            chk({tag, "_out_valid"}, {31'd0, bus.out_valid}, {31'd0, exp_v});
            if (exp_v) begin
                chk({tag, "_out_data"}, {16'd0, bus.out_data}, {16'd0, 16'(exp_val[k])});
                last_out = exp_val[k];
                k++;
            end
            chk({tag, "_frame_done"}, {31'd0, bus.frame_done},
                {31'd0, (i == samples.size() - 1)});
            chk({tag, "_busy"}, {31'd0, bus.busy}, {31'd0, (i != samples.size() - 1)});
        end
        bus.in_valid = 1'b0;
        tick();
        chk({tag, "_tail_valid"}, {31'd0, bus.out_valid}, 32'd0);
        chk({tag, "_tail_done"}, {31'd0, bus.frame_done}, 32'd0);
        chk({tag, "_hold_data"}, {16'd0, bus.out_data}, {16'd0, 16'(last_out)});
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_size  = 4'd0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 16'd0;
`ifdef AVG_POOL_EN
        bus.avg_mode  = 1'b0;
`endif
        repeat (3) tick();
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_data", {16'd0, bus.out_data}, 32'd0);
        chk("rst_frame_done", {31'd0, bus.frame_done}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Samples while IDLE are ignored
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 16'(i + 40);
            tick();
            chk("idle_busy", {31'd0, bus.busy}, 32'd0);
            chk("idle_out_valid", {31'd0, bus.out_valid}, 32'd0);
        end
        bus.in_valid = 1'b0;

        // N=4 ramp
        cfg(4, 1'b0, 1'b1);
        load_ramp(16);
        exp_pos = '{5, 7, 13, 15};
        exp_val = '{5, 7, 13, 15};
        run_frame("n4_ramp", 1'b0);

        // N=2 negatives: signed compare
        cfg(2, 1'b0, 1'b1);
        samples = '{-5, -3, -8, -1};
        exp_pos = '{3};
        exp_val = '{-1};
        run_frame("n2_signed", 1'b0);

        // N=4 with maxima in different window positions
        cfg(4, 1'b0, 1'b1);
        samples = '{9, -2, 3, 100, 1, 4, -7, -50, -1, -3, 20, 2, -4, -9, 25, 5};
        exp_pos = '{5, 7, 13, 15};
        exp_val = '{9, 100, -1, 25};
        run_frame("n4_mixed", 1'b0);

        // N=5: trailing row/column dropped
        cfg(5, 1'b0, 1'b1);
        load_ramp(25);
        exp_pos = '{6, 8, 16, 18};
        exp_val = '{6, 8, 16, 18};
        run_frame("n5_odd", 1'b0);

        // N=4 with gaps and an ignored mid-frame config
        cfg(4, 1'b0, 1'b1);
        load_ramp(16);
        exp_pos = '{5, 7, 13, 15};
        exp_val = '{5, 7, 13, 15};
        run_frame("n4_gaps", 1'b1);

        // Oversized config clamps to 8
        cfg(12, 1'b0, 1'b1);
        load_ramp(64);
        exp_pos.delete();
        exp_val.delete();
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                exp_pos.push_back((2 * i + 1) * 8 + 2 * j + 1);
                exp_val.push_back((2 * i + 1) * 8 + 2 * j + 1);
            end
        end
        run_frame("n12_clamp", 1'b0);

        // Undersized config is ignored
        cfg(1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 16'(i + 7);
            tick();
            chk("n1_busy", {31'd0, bus.busy}, 32'd0);
            chk("n1_out_valid", {31'd0, bus.out_valid}, 32'd0);
        end
        bus.in_valid = 1'b0;

        // Reset mid-frame
        cfg(4, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 16'(i);
            tick();
        end
        bus.in_valid = 1'b0;
        chk("pre_rst_out_data", {16'd0, bus.out_data}, 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("midrst_out_data", {16'd0, bus.out_data}, 32'd0);
        chk("midrst_frame_done", {31'd0, bus.frame_done}, 32'd0);
        chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_done", {31'd0, bus.frame_done}, 32'd0);
        cfg(4, 1'b0, 1'b1);
        load_ramp(16);
        exp_pos = '{5, 7, 13, 15};
        exp_val = '{5, 7, 13, 15};
        run_frame("n4_after_rst", 1'b0);

`ifdef AVG_POOL_EN
        // Average pooling of the same ramp
        cfg(4, 1'b1, 1'b1);
        load_ramp(16);
        exp_pos = '{5, 7, 13, 15};
        exp_val = '{2, 4, 10, 12};
        run_frame("n4_avg", 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
